sort_engine: RTL

- Memory-side initiator that performs an in-place ascending selection sort of N_ELEM 64-bit doublewords held in Data_Memory.
- Drives Data_Memory's address, write_data, memoryread and memorywrite ports and consumes its read_data.
- Lets the selection-sort workload run as a hardware accelerator, with the single-cycle core idle or stalled while it runs.
- Data_Memory behaviour it relies on: byte-addressed, little-endian 8-byte words; read is combinational (read_data valid in the same cycle as address with memoryread=1); write commits on posedge clk when memorywrite=1.

---
 rtl/sort_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sort_engine.sv
// In-place ascending selection sort of N_ELEM 64-bit doublewords in Data_Memory.
// Every memory-side output is registered and loaded with the value for the state being entered.
module sort_engine #(
    parameter int          N_ELEM    = 8,
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [63:0]      address,
    output logic [63:0]      write_data,
    output logic             memoryread,
    output logic             memorywrite,
    input  logic [63:0]      read_data,
    output logic [CNT_W-1:0] swap_count,
    output logic [2:0]       dbg_state
);

    // Index registers must hold N_ELEM itself because j is bumped past the last element.
    localparam int IDX_W = (N_ELEM < 2) ? 1 : $clog2(N_ELEM + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = (N_ELEM < 2) ? '0 : IDX_W'(N_ELEM - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SCAN   = 3'd2,
        S_SWAP_A = 3'd3,
        S_SWAP_B = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] min_idx;
    logic [63:0]      min_val;
    logic [63:0]      cur_val;

    logic             scan_lt;
    logic [IDX_W-1:0] scan_min_idx;
    logic [63:0]      scan_min_val;
    logic [IDX_W-1:0] i_inc;
    logic [IDX_W-1:0] j_inc;

    function automatic logic [63:0] addr_of(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + {{(61 - IDX_W){1'b0}}, idx, 3'b000};
    endfunction

    // Running minimum including the element being read this cycle; strict compare keeps the first occurrence.
    always_comb begin
        scan_lt      = read_data < min_val;
        scan_min_idx = scan_lt ? j : min_idx;
        scan_min_val = scan_lt ? read_data : min_val;
        i_inc        = i + 1'b1;
        j_inc        = j + 1'b1;
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            i           <= '0;
            j           <= '0;
            min_idx     <= '0;
            min_val     <= '0;
            cur_val     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            address     <= '0;
            write_data  <= '0;
            memoryread  <= 1'b0;
            memorywrite <= 1'b0;
            swap_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        swap_count <= '0;
                        i          <= '0;
                        busy       <= 1'b1;
                        if (N_ELEM < 2) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= S_LOAD;
                            memoryread <= 1'b1;
                            address    <= addr_of('0);
                        end
                    end
                end
                S_LOAD: begin
                    cur_val <= read_data;
                    min_val <= read_data;
                    min_idx <= i;
                    j       <= i_inc;
                    address <= addr_of(i_inc);
                    state   <= S_SCAN;
                end
                S_SCAN: begin
                    min_val <= scan_min_val;
                    min_idx <= scan_min_idx;
                    j       <= j_inc;
                    if (j == LAST_IDX) begin
                        memoryread <= 1'b0;
                        if (scan_min_idx != i) begin
                            state       <= S_SWAP_A;
                            memorywrite <= 1'b1;
                            address     <= addr_of(i);
                            write_data  <= scan_min_val;
                        end else begin
                            state   <= S_NEXT;
                            address <= '0;
                        end
                    end else begin
                        address <= addr_of(j_inc);
                    end
                end
                S_SWAP_A: begin
                    state      <= S_SWAP_B;
                    address    <= addr_of(min_idx);
                    write_data <= cur_val;
                end
                S_SWAP_B: begin
                    swap_count  <= swap_count + CNT_W'(1);
                    state       <= S_NEXT;
                    memorywrite <= 1'b0;
                    address     <= '0;
                    write_data  <= '0;
                end
                S_NEXT: begin
                    i <= i_inc;
                    if (i_inc == LAST_IDX) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= S_LOAD;
                        memoryread <= 1'b1;
                        address    <= addr_of(i_inc);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    address     <= '0;
                    write_data  <= '0;
                    memoryread  <= 1'b0;
                    memorywrite <= 1'b0;
                end
            endcase
        end
    end

endmodule
